// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with pending/active content banks.
// New contents are committed only at a frame boundary, so no frame mixes old and new digits.
module seg_scan_ctrl #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  points,
  input  logic [3:0]  blank,
  output logic [1:0]  s,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  points;
    logic [3:0]  blank;
  } bank_t;

  logic [CW-1:0] r_presc;
  logic [1:0]    r_idx;
  bank_t         r_pend;
  bank_t         r_act;
  logic          r_busy;
  logic [1:0]    r_s;
  logic [3:0]    r_an;
  logic [3:0]    r_digit;
  logic          r_dp;
  logic          r_frameDone;

  logic          w_tick;
  logic          w_wrap;
  logic          w_commit;
  logic          w_lit;
  logic [3:0]    w_anNext;
  logic [3:0]    w_digitNext;
  logic          w_dpNext;

  assign w_tick   = en && (r_presc == LAST);
  assign w_wrap   = w_tick && (r_idx == 2'd3);
  // With scanning stopped there is no frame to tear, so pending contents commit immediately.
  assign w_commit = r_busy && (w_wrap || !en);

  assign w_lit       = en && !r_act.blank[r_idx];
  assign w_anNext    = w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
  assign w_digitNext = r_act.data[{r_idx, 2'b00} +: 4];
  assign w_dpNext    = w_lit ? ~r_act.points[r_idx] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (en) begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + CW'(1);
      end
    end
  end

  // A load coinciding with a commit moves the old pending value forward and keeps busy set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_act  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_commit) begin
        r_act <= r_pend;
      end
      if (load) begin
        r_pend <= {data_in, points, blank};
      end
      r_busy <= load | (r_busy & ~w_commit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s         <= 2'b00;
      r_an        <= 4'b1111;
      r_digit     <= 4'b0000;
      r_dp        <= 1'b1;
      r_frameDone <= 1'b0;
    end else begin
      r_s         <= r_idx;
      r_an        <= w_anNext;
      r_digit     <= w_digitNext;
      r_dp        <= w_dpNext;
      r_frameDone <= w_wrap;
    end
  end

  assign s          = r_s;
  assign an         = r_an;
  assign digit      = r_digit;
  assign dp         = r_dp;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 50000, giving clk cycles per digit slot (legal range 2..2^20).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit, scan enable; 0 freezes scanning and darkens the display.
REQ-005 The block SHALL have port load, input, 1 bit, a single-cycle request to accept new display contents.
REQ-006 The block SHALL have port data_in, input, 16 bits, four hex nibbles; digit k is data_in[4k+3:4k].
REQ-007 The block SHALL have port points, input, 4 bits, decimal point per digit, active-high.
REQ-008 The block SHALL have port blank, input, 4 bits, per-digit blank, active-high.
REQ-009 The block SHALL have port s, output, 2 bits, current digit index, driving the downstream 4-bit 4:1 mux select.
REQ-010 The block SHALL have port an, output, 4 bits, active-low one-hot anode enables.
REQ-011 The block SHALL have port digit, output, 4 bits, the active nibble selected by s.
REQ-012 The block SHALL have port dp, output, 1 bit, active-low decimal point for the current digit.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a loaded value is pending commit.
REQ-014 The block SHALL have port frame_done, output, 1 bit, one-cycle pulse on every frame wrap.

Function
REQ-015 The prescaler SHALL count 0..PRESCALE-1 while en=1, generate tick at count PRESCALE-1, and wrap to 0 on that cycle.
REQ-016 The internal index idx SHALL advance 0->1->2->3->0 on each tick; idx and the prescaler SHALL hold while en=0.
REQ-017 Two banks SHALL exist, pending and active, each holding 16 data, 4 points and 4 blank bits.
REQ-018 load=1 SHALL write data_in/points/blank into pending and set busy=1 on the next cycle; a load while busy=1 SHALL overwrite pending (latest wins).
REQ-019 Commit (pending->active, busy->0) SHALL occur on the cycle where tick=1 and idx=3, so no frame mixes old and new contents.
REQ-020 When en=0 and busy=1, commit SHALL occur on the next clock edge.
REQ-021 Simultaneous load and commit SHALL commit the old pending value, capture the new value into pending, and leave busy=1.
REQ-022 frame_done SHALL be 1 for exactly the one cycle following each idx 3->0 wrap, whether or not a commit occurred.
REQ-023 s, an, digit and dp SHALL be registered with one cycle of latency from idx and the active bank, and SHALL always be mutually coherent.
REQ-024 With en=1 and active.blank[idx]=0: an=~(1<<idx), digit=active.data nibble idx, dp=~active.points[idx].
REQ-025 With en=0 or active.blank[idx]=1: an=4'b1111 and dp=1, while s and digit still follow idx.

Reset
REQ-026 While rst=1, the block SHALL clear the prescaler, idx, both banks and busy to 0, and drive s=00, an=1111, digit=0000, dp=1, busy=0, frame_done=0, independent of clk.
REQ-027 Reset mid-frame or mid-pending SHALL discard the pending value without committing it.
REQ-028 The first tick SHALL occur PRESCALE cycles after rst deasserts with en=1.

Verification (PRESCALE=4)
REQ-029 Reset release, en=1, no load -> s steps 0,1,2,3 every 4 cycles; an cycles 1110,1101,1011,0111; digit=0; dp=1.
REQ-030 load data_in=16'h4321, points=0010 mid-frame -> busy=1 until wrap; the next frame shows digits 1,2,3,4; dp=0 only at s=1; frame_done pulses once per 16 cycles.
REQ-031 load h1111 then hAAAA on consecutive cycles before wrap -> only hAAAA is ever displayed; busy clears at wrap.
REQ-032 load coincident with the commit cycle -> the old pending value is shown, busy stays 1, and the new value is committed at the following wrap.
REQ-033 blank=0100 active -> an=1111 during s=2; other digits normal; en=0 with pending load -> an=1111, commit next cycle, idx frozen.
REQ-034 rst asserted asynchronously mid-frame with busy=1 -> outputs take reset values immediately; after release, pending is lost and active=0.
